// File: rtl/fifo_dual_arb.sv
// Round-robin arbiter that packs up to two requester words per cycle into a dual-enqueue output stage.
// Optional per-requester saturating grant counters are enabled by defining FIFO_DUAL_ARB_CNT_EN.
module fifo_dual_arb #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arb_en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_in_valid,
  output logic                     inA_enque_en,
  output logic                     inB_enque_en,
  output logic [DWIDTH-1:0]        inA_data,
  output logic [DWIDTH-1:0]        inB_data,
  output logic                     stage_busy
`ifdef FIFO_DUAL_ARB_CNT_EN
  ,
  output logic [NREQ*16-1:0]       grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NREQ);

  function automatic logic [PTR_W-1:0] wrap_idx(input int v);
    return PTR_W'(v % NREQ);
  endfunction

  logic              a_valid_q, a_valid_d;
  logic              b_valid_q, b_valid_d;
  logic [DWIDTH-1:0] a_data_q, a_data_d;
  logic [DWIDTH-1:0] b_data_q, b_data_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              accept;
  logic              load_ok;
  logic              first_found, second_found;
  logic [PTR_W-1:0]  first_idx, second_idx;
  logic [PTR_W-1:0]  cand;
  logic [NREQ-1:0]   grant_vec;

  // Scan from rr_ptr upward; the first two valid requesters become slots A and B.
  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    cand         = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_idx(int'(rr_ptr_q) + k);
      if (req_valid[cand]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = cand;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = cand;
        end
      end
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path leaves a latch.
  always_comb begin
    accept    = a_valid_q & fifo_in_valid;
    load_ok   = arb_en & (~a_valid_q | fifo_in_valid) & ~rst;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    rr_ptr_d  = rr_ptr_q;
    grant_vec = '0;

    if (accept) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end

    if (load_ok) begin
      a_valid_d = first_found;
      b_valid_d = first_found & second_found;
      if (first_found) begin
        a_data_d             = req_data[int'(first_idx)*DWIDTH +: DWIDTH];
        grant_vec[first_idx] = 1'b1;
        rr_ptr_d             = wrap_idx(int'(first_idx) + 1);
      end
      if (first_found && second_found) begin
        b_data_d              = req_data[int'(second_idx)*DWIDTH +: DWIDTH];
        grant_vec[second_idx] = 1'b1;
        rr_ptr_d              = wrap_idx(int'(second_idx) + 1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Outputs are masked by rst so they read 0 even before the first reset edge.
  assign req_ready    = grant_vec;
  assign inA_enque_en = a_valid_q & ~rst;
  assign inB_enque_en = b_valid_q & ~rst;
  assign inA_data     = a_data_q;
  assign inB_data     = b_data_q;
  assign stage_busy   = a_valid_q & ~rst;

`ifdef FIFO_DUAL_ARB_CNT_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_vec[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  // NOTE: the counter array is small and architecturally visible, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_dual_arb.sv
// Directed bench for fifo_dual_arb: expected enqueue pairs go into a scoreboard queue,
// and a negedge monitor pops and compares whenever the downstream accepts the stage.
module tb_fifo_dual_arb;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   arb_en = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DWIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_in_valid = 1'b0;
  logic                   inA_enque_en, inB_enque_en;
  logic [DWIDTH-1:0]      inA_data, inB_data;
  logic                   stage_busy;
`ifdef FIFO_DUAL_ARB_CNT_EN
  logic [NREQ*16-1:0]     grant_cnt;
`endif

  fifo_dual_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .arb_en        (arb_en),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_in_valid (fifo_in_valid),
    .inA_enque_en  (inA_enque_en),
    .inB_enque_en  (inB_enque_en),
    .inA_data      (inA_data),
    .inB_data      (inB_data),
    .stage_busy    (stage_busy)
`ifdef FIFO_DUAL_ARB_CNT_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        bv;
    logic [31:0] b;
  } pair_t;

  pair_t exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    tag     = 0;

  function automatic logic [31:0] dat(input int t, input int i);
    return 32'((t << 8) | i);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic push(input int a, input logic bv, input int b);
    pair_t p;
    p.a  = dat(tag, a);
    p.bv = bv;
    p.b  = bv ? dat(tag, b) : 32'h0;
    exp_q.push_back(p);
  endtask

  // One cycle: drive inputs just after the edge, check req_ready on the falling edge.
  task automatic cyc(input logic [3:0] rv, input logic fv, input logic ae, input logic r,
                     input logic [3:0] exp_rdy, input string nm);
    @(posedge clk);
    #1;
    tag++;
    rst           = r;
    req_valid     = rv;
    fifo_in_valid = fv;
    arb_en        = ae;
    for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = dat(tag, i);
    @(negedge clk);
    check({nm, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
  endtask

  // Monitor: a pair leaves the stage when strobes are up and the downstream has room.
  always @(negedge clk) begin
    if (!rst && fifo_in_valid && (inA_enque_en || inB_enque_en)) begin
      pair_t p;
      check("B strobe implies A strobe", 32'(inA_enque_en), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected enqueue", 32'd1, 32'd0);
      end else begin
        p = exp_q.pop_front();
        check("slot A data", inA_data, p.a);
        check("slot B valid", 32'(inB_enque_en), 32'(p.bv));
        if (p.bv) check("slot B data", inB_data, p.b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held_tag;

    // Reset with requests present: nothing may be granted or strobed.
    for (int n = 0; n < 2; n++) begin
      cyc(4'hF, 1'b1, 1'b1, 1'b1, 4'h0, "reset");
      check("reset inA_enque_en", 32'(inA_enque_en), 32'd0);
      check("reset inB_enque_en", 32'(inB_enque_en), 32'd0);
      check("reset stage_busy", 32'(stage_busy), 32'd0);
    end

    // All requesting: pairs {0,1},{2,3},{0,1} back to back.
    cyc(4'hF, 1'b1, 1'b1, 1'b0, 4'b0011, "rr pair01"); push(0, 1'b1, 1);
    cyc(4'hF, 1'b1, 1'b1, 1'b0, 4'b1100, "rr pair23"); push(2, 1'b1, 3);
    cyc(4'hF, 1'b1, 1'b1, 1'b0, 4'b0011, "rr pair01b"); push(0, 1'b1, 1);
    cyc(4'h0, 1'b1, 1'b1, 1'b0, 4'b0000, "no requests");

    // Single requester 2, pointer lands on 3 and stays there.
    cyc(4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, "single r2"); push(2, 1'b0, 0);
    cyc(4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, "single r2 ptr3"); push(2, 1'b0, 0);
    check("single inA_enque_en", 32'(inA_enque_en), 32'd1);
    check("single inB_enque_en", 32'(inB_enque_en), 32'd0);
    cyc(4'hF, 1'b1, 1'b1, 1'b0, 4'b1001, "wrap pair30"); push(3, 1'b1, 0);
    held_tag = tag;

    // Downstream full for 5 cycles: stage holds, no grants.
    for (int n = 0; n < 5; n++) begin
      cyc(4'hF, 1'b0, 1'b1, 1'b0, 4'b0000, "stall");
      check("stall inA_enque_en", 32'(inA_enque_en), 32'd1);
      check("stall inB_enque_en", 32'(inB_enque_en), 32'd1);
      check("stall inA_data", inA_data, dat(held_tag, 3));
      check("stall inB_data", inB_data, dat(held_tag, 0));
    end
    cyc(4'hF, 1'b1, 1'b1, 1'b0, 4'b0110, "release pair12"); push(1, 1'b1, 2);

    // Arbitration disabled: pending pair drains, then the stage stays empty.
    cyc(4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, "arb off drain");
    cyc(4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, "arb off idle1");
    check("arb off stage_busy", 32'(stage_busy), 32'd0);
    cyc(4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, "arb off idle2");
    check("arb off inA_enque_en", 32'(inA_enque_en), 32'd0);

    // Load a pair (pointer 3 -> grants 0,1), then reset before it is accepted.
    cyc(4'b0011, 1'b1, 1'b1, 1'b0, 4'b0011, "pre-reset load");
    cyc(4'hF, 1'b0, 1'b1, 1'b1, 4'b0000, "mid reset");
    check("mid reset inA_enque_en", 32'(inA_enque_en), 32'd0);
    check("mid reset stage_busy", 32'(stage_busy), 32'd0);
    cyc(4'hF, 1'b1, 1'b1, 1'b0, 4'b0011, "post reset ptr0"); push(0, 1'b1, 1);
    check("post reset inA_enque_en", 32'(inA_enque_en), 32'd0);
    cyc(4'h0, 1'b1, 1'b1, 1'b0, 4'b0000, "drain");
    cyc(4'h0, 1'b1, 1'b1, 1'b0, 4'b0000, "idle");
    check("idle stage_busy", 32'(stage_busy), 32'd0);

`ifdef FIFO_DUAL_ARB_CNT_EN
    check("cnt r0 after reset", 32'(grant_cnt[15:0]), 32'd1);
    for (int n = 0; n < 70000; n++) begin
      cyc(4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, "sat r0"); push(0, 1'b0, 0);
    end
    cyc(4'h0, 1'b1, 1'b1, 1'b0, 4'b0000, "sat drain");
    check("cnt r0 saturated", 32'(grant_cnt[15:0]), 32'h0000FFFF);
    check("cnt r1 untouched", 32'(grant_cnt[31:16]), 32'd1);
`endif

    @(negedge clk);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
